// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: configurable UART transmitter (5..9 data bits, none/odd/even
// parity, 1 or 2 stop bits) fed from an internal TX FIFO.
//
// Write handshake: a word on send_data is accepted on any rising edge where
// send_en && send_ready. send_ready reflects the registered FIFO level, so a
// pop in the same cycle never makes room for that cycle's write. A write
// attempted while full is discarded and flagged by a one-cycle send_drop
// pulse on the following cycle.
module uart_tx_cfg #(
  parameter int CLK_FRE    = 50,
  parameter int UART_RATE  = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              send_en,
  input  logic [DATA_BITS-1:0]              send_data,
  output logic                              send_ready,
  output logic                              send_drop,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
  output logic                              send_busy,
  output logic                              tx_pin
);

  localparam int RATE_CNT = CLK_FRE * 1000000 / UART_RATE - 1;
  localparam int CW       = (RATE_CNT > 0) ? $clog2(RATE_CNT + 1) : 1;
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int LW       = $clog2(FIFO_DEPTH + 1);
  localparam int IW       = $clog2(DATA_BITS);

  localparam logic [CW-1:0] RATE_MAX  = CW'(RATE_CNT);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(FIFO_DEPTH);
  localparam logic          ODD_PAR   = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                 state, state_nxt;
  logic [CW-1:0]          baud_cnt;
  logic [IW-1:0]          bit_idx;
  logic                   stop_idx;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   par_bit;
  logic                   bit_done;
  logic                   pop;
  logic                   push;
  logic                   fifo_empty;

  logic [DATA_BITS-1:0]   mem [FIFO_DEPTH];
  logic [PW-1:0]          wr_ptr, rd_ptr;
  logic [LW-1:0]          level;

  assign bit_done   = (baud_cnt == RATE_MAX);
  assign fifo_empty = (level == '0);
  assign send_ready = (level != LVL_FULL);
  assign push       = send_en && send_ready;
  assign fifo_level = level;

  // Next-state logic; pop is asserted whenever a new frame is launched.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START:  if (bit_done) state_nxt = S_DATA;
      S_DATA: begin
        if (bit_done && bit_idx == IDX_LAST)
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: if (bit_done) state_nxt = S_STOP;
      S_STOP: begin
        if (bit_done && stop_idx == STOP_LAST) begin
          if (!fifo_empty) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM state, bit timing counters and the per-frame shift/parity copy.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      baud_cnt  <= '0;
      bit_idx   <= '0;
      stop_idx  <= 1'b0;
      shift_reg <= '0;
      par_bit   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE || bit_done) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + CW'(1);
      if (pop) begin
        shift_reg <= mem[rd_ptr];
        par_bit   <= (^mem[rd_ptr]) ^ ODD_PAR;
        bit_idx   <= '0;
      end else if (state == S_DATA && bit_done) begin
        shift_reg <= shift_reg >> 1;
        bit_idx   <= (bit_idx == IDX_LAST) ? '0 : bit_idx + IW'(1);
      end
      if (state == S_STOP && bit_done)
        stop_idx <= (stop_idx == STOP_LAST) ? 1'b0 : 1'b1;
    end
  end

  // Registered line driver; lags the state by one clock so every bit keeps
  // its full length on the pin.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_pin    <= 1'b1;
      send_busy <= 1'b0;
    end else begin
      send_busy <= (state != S_IDLE) || !fifo_empty;
      case (state)
        S_START:  tx_pin <= 1'b0;
        S_DATA:   tx_pin <= shift_reg[0];
        S_PARITY: tx_pin <= par_bit;
        default:  tx_pin <= 1'b1;
      endcase
    end
  end

  // FIFO storage; contents need no reset because the level gates all reads.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= send_data;
  end

  // FIFO pointers, level and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      level     <= '0;
      send_drop <= 1'b0;
    end else begin
      send_drop <= send_en && !send_ready;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed bench for uart_tx_cfg across six configurations.
module tb_uart_tx_cfg;

  logic clk = 1'b0;
  logic rst;

  // clock: 10 time units per cycle
  always #5 clk = ~clk;

  // A: 8N1 4 clk/bit depth 16
  logic en_a; logic [7:0] data_a; logic ready_a, drop_a, busy_a, tx_a; logic [4:0] level_a;
  // B: 8E1
  logic en_b; logic [7:0] data_b; logic ready_b, drop_b, busy_b, tx_b; logic [4:0] level_b;
  // C: 8O1
  logic en_c; logic [7:0] data_c; logic ready_c, drop_c, busy_c, tx_c; logic [4:0] level_c;
  // D: 7E2
  logic en_d; logic [6:0] data_d; logic ready_d, drop_d, busy_d, tx_d; logic [4:0] level_d;
  // E: 8N1 depth 4
  logic en_e; logic [7:0] data_e; logic ready_e, drop_e, busy_e, tx_e; logic [2:0] level_e;
  // F: 8N1 50 MHz / 115200
  logic en_f; logic [7:0] data_f; logic ready_f, drop_f, busy_f, tx_f; logic [4:0] level_f;

  uart_tx_cfg #(.CLK_FRE(1), .UART_RATE(250000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_a (.clk(clk), .rst(rst), .send_en(en_a), .send_data(data_a), .send_ready(ready_a),
         .send_drop(drop_a), .fifo_level(level_a), .send_busy(busy_a), .tx_pin(tx_a));
  uart_tx_cfg #(.CLK_FRE(1), .UART_RATE(250000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_b (.clk(clk), .rst(rst), .send_en(en_b), .send_data(data_b), .send_ready(ready_b),
         .send_drop(drop_b), .fifo_level(level_b), .send_busy(busy_b), .tx_pin(tx_b));
  uart_tx_cfg #(.CLK_FRE(1), .UART_RATE(250000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_c (.clk(clk), .rst(rst), .send_en(en_c), .send_data(data_c), .send_ready(ready_c),
         .send_drop(drop_c), .fifo_level(level_c), .send_busy(busy_c), .tx_pin(tx_c));
  uart_tx_cfg #(.CLK_FRE(1), .UART_RATE(250000), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16))
    u_d (.clk(clk), .rst(rst), .send_en(en_d), .send_data(data_d), .send_ready(ready_d),
         .send_drop(drop_d), .fifo_level(level_d), .send_busy(busy_d), .tx_pin(tx_d));
  uart_tx_cfg #(.CLK_FRE(1), .UART_RATE(250000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4))
    u_e (.clk(clk), .rst(rst), .send_en(en_e), .send_data(data_e), .send_ready(ready_e),
         .send_drop(drop_e), .fifo_level(level_e), .send_busy(busy_e), .tx_pin(tx_e));
  uart_tx_cfg #(.CLK_FRE(50), .UART_RATE(115200), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16))
    u_f (.clk(clk), .rst(rst), .send_en(en_f), .send_data(data_f), .send_ready(ready_f),
         .send_drop(drop_f), .fifo_level(level_f), .send_busy(busy_f), .tx_pin(tx_f));

  // selected instance for the shared line-measurement tasks
  int   sel = 0;
  logic tx_sel, busy_sel;
  always_comb begin
    tx_sel   = 1'b1;
    busy_sel = 1'b0;
    case (sel)
      0: begin tx_sel = tx_a; busy_sel = busy_a; end
      1: begin tx_sel = tx_b; busy_sel = busy_b; end
      2: begin tx_sel = tx_c; busy_sel = busy_c; end
      3: begin tx_sel = tx_d; busy_sel = busy_d; end
      4: begin tx_sel = tx_e; busy_sel = busy_e; end
      5: begin tx_sel = tx_f; busy_sel = busy_f; end
      default: ;
    endcase
  end

  int n_cmp = 0;
  int n_err = 0;

  // expected line model: one frame written clock by clock into an idle-high line
  function automatic logic [255:0] put_frame(input logic [255:0] base, input logic [15:0] bits,
                                             input int nbits, input int cpb, input int offset);
    logic [255:0] r;
    r = base;
    for (int b = 0; b < nbits; b++)
      for (int c = 0; c < cpb; c++)
        r[offset + b * cpb + c] = bits[b];
    return r;
  endfunction

  // driver: one-cycle write strobe on the chosen instance (call #1 after an edge)
  task automatic pulse_en(input int which, input logic [8:0] d);
    case (which)
      0: begin en_a = 1'b1; data_a = d[7:0]; end
      1: begin en_b = 1'b1; data_b = d[7:0]; end
      2: begin en_c = 1'b1; data_c = d[7:0]; end
      3: begin en_d = 1'b1; data_d = d[6:0]; end
      4: begin en_e = 1'b1; data_e = d[7:0]; end
      default: begin en_f = 1'b1; data_f = d[7:0]; end
    endcase
    @(posedge clk); #1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; en_e = 1'b0; en_f = 1'b0;
  endtask

  // measurement: number of high samples before the start bit (-1 on timeout)
  task automatic wait_fall(output int n_high);
    bit seen;
    seen   = 1'b0;
    n_high = 0;
    while (!seen && n_high < 200) begin
      @(negedge clk);
      if (tx_sel === 1'b0) seen = 1'b1;
      else                 n_high++;
    end
    if (!seen) n_high = -1;
  endtask

  // measurement: one line sample per clock, first sample taken now
  task automatic capture(input int nclk, output logic [255:0] line);
    line    = '1;
    line[0] = tx_sel;
    for (int k = 1; k < nclk; k++) begin
      @(negedge clk);
      line[k] = tx_sel;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (tx_a !== 1'b1)     begin n_err++; $display("FAIL reset_tx got %b want 1", tx_a); end
    n_cmp++; if (ready_a !== 1'b1)  begin n_err++; $display("FAIL reset_ready got %b want 1", ready_a); end
    n_cmp++; if (drop_a !== 1'b0)   begin n_err++; $display("FAIL reset_drop got %b want 0", drop_a); end
    n_cmp++; if (level_a !== 5'd0)  begin n_err++; $display("FAIL reset_level got %0d want 0", level_a); end
    n_cmp++; if (busy_a !== 1'b0)   begin n_err++; $display("FAIL reset_busy got %b want 0", busy_a); end
    n_cmp++; if (level_e !== 3'd0)  begin n_err++; $display("FAIL reset_level_e got %0d want 0", level_e); end
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (tx_a !== 1'b1 || busy_a !== 1'b0)
      begin n_err++; $display("FAIL idle_after_reset got tx=%b busy=%b want tx=1 busy=0", tx_a, busy_a); end
  endtask

  // send one word on an instance and check latency, line shape and busy drop
  task automatic run_frame(input string name, input int which, input logic [8:0] d,
                           input logic [15:0] bits, input int nbits);
    int nh;
    logic [255:0] line, exp;
    sel = which;
    pulse_en(which, d);
    wait_fall(nh);
    n_cmp++; if (nh !== 2) begin n_err++; $display("FAIL %s_latency got %0d want 2", name, nh); end
    capture(nbits * 4, line);
    exp = put_frame('1, bits, nbits, 4, 0);
    n_cmp++; if (line !== exp) begin n_err++; $display("FAIL %s_line got %h want %h", name, line, exp); end
    n_cmp++; if (busy_sel !== 1'b1) begin n_err++; $display("FAIL %s_busy_last got %b want 1", name, busy_sel); end
    @(negedge clk);
    n_cmp++; if (busy_sel !== 1'b0 || tx_sel !== 1'b1)
      begin n_err++; $display("FAIL %s_busy_end got busy=%b tx=%b want 0/1", name, busy_sel, tx_sel); end
  endtask

  task automatic test_8n1();
    @(posedge clk); #1;
    run_frame("8n1_a5", 0, 9'h0A5, 16'({1'b1, 8'hA5, 1'b0}), 10);
  endtask

  task automatic test_parity();
    @(posedge clk); #1;
    run_frame("even_a5", 1, 9'h0A5, 16'({1'b1, 1'b0, 8'hA5, 1'b0}), 11);
    @(posedge clk); #1;
    run_frame("odd_a5", 2, 9'h0A5, 16'({1'b1, 1'b1, 8'hA5, 1'b0}), 11);
  endtask

  task automatic test_7e2();
    @(posedge clk); #1;
    run_frame("7e2_55", 3, 9'h055, 16'({1'b1, 1'b1, 1'b0, 7'h55, 1'b0}), 11);
  endtask

  task automatic test_fifo_full();
    int exp_lvl [6] = '{1, 1, 2, 3, 4, 4};
    logic exp_rdy [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic exp_drp [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [255:0] line, exp;
    sel = 4;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      en_e   = 1'b1;
      data_e = 8'(i + 1);
      @(posedge clk); #1;
      n_cmp++; if (level_e !== 3'(exp_lvl[i]) || ready_e !== exp_rdy[i] || drop_e !== exp_drp[i])
        begin n_err++; $display("FAIL fifo_write%0d got lvl=%0d rdy=%b drop=%b want lvl=%0d rdy=%b drop=%b",
                                i, level_e, ready_e, drop_e, exp_lvl[i], exp_rdy[i], exp_drp[i]); end
    end
    en_e = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (drop_e !== 1'b0 || level_e !== 3'd4)
      begin n_err++; $display("FAIL fifo_after_drop got drop=%b lvl=%0d want 0/4", drop_e, level_e); end
    // line started 4 clocks ago; resume at offset 4 of the 5-frame stream
    @(negedge clk);
    capture(196, line);
    exp = '1;
    for (int f = 0; f < 5; f++)
      exp = put_frame(exp, 16'({1'b1, 8'(f + 1), 1'b0}), 10, 4, f * 40);
    exp = {4'hF, exp[255:4]};
    n_cmp++; if (line !== exp) begin n_err++; $display("FAIL fifo_b2b_line got %h want %h", line, exp); end
    @(negedge clk);
    n_cmp++; if (busy_e !== 1'b0 || tx_e !== 1'b1 || level_e !== 3'd0)
      begin n_err++; $display("FAIL fifo_drain got busy=%b tx=%b lvl=%0d want 0/1/0", busy_e, tx_e, level_e); end
  endtask

  task automatic test_reset_mid();
    sel = 0;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      en_a   = 1'b1;
      data_a = 8'(i * 8'h11);
      @(posedge clk); #1;
    end
    en_a = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    n_cmp++; if (tx_a !== 1'b0 || level_a !== 5'd2)
      begin n_err++; $display("FAIL mid_bit3 got tx=%b lvl=%0d want 0/2", tx_a, level_a); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (tx_a !== 1'b1 || level_a !== 5'd0 || busy_a !== 1'b0 || ready_a !== 1'b1)
      begin n_err++; $display("FAIL mid_reset got tx=%b lvl=%0d busy=%b rdy=%b want 1/0/0/1",
                              tx_a, level_a, busy_a, ready_a); end
    run_frame("after_reset_3c", 0, 9'h03C, 16'({1'b1, 8'h3C, 1'b0}), 10);
  endtask

  task automatic test_baud_50m();
    int nh, lc, hc, lows;
    sel = 5;
    @(posedge clk); #1;
    pulse_en(5, 9'h0FF);
    wait_fall(nh);
    n_cmp++; if (nh !== 2) begin n_err++; $display("FAIL 50m_latency got %0d want 2", nh); end
    lc = 0;
    while (tx_sel === 1'b0 && lc < 1000) begin lc++; @(negedge clk); end
    n_cmp++; if (lc !== 434) begin n_err++; $display("FAIL 50m_start_len got %0d want 434", lc); end
    hc = 0; lows = 0;
    while (busy_sel === 1'b1 && hc < 5000) begin
      if (tx_sel !== 1'b1) lows++;
      hc++;
      @(negedge clk);
    end
    n_cmp++; if (hc !== 3906 || lows !== 0)
      begin n_err++; $display("FAIL 50m_high_len got %0d lows=%0d want 3906 lows=0", hc, lows); end
    n_cmp++; if (lc + hc !== 4340) begin n_err++; $display("FAIL 50m_frame_len got %0d want 4340", lc + hc); end
  endtask

  initial begin
    rst = 1'b1;
    en_a = 1'b0; en_b = 1'b0; en_c = 1'b0; en_d = 1'b0; en_e = 1'b0; en_f = 1'b0;
    data_a = '0; data_b = '0; data_c = '0; data_d = '0; data_e = '0; data_f = '0;
    test_reset();
    test_8n1();
    test_parity();
    test_7e2();
    test_fifo_full();
    test_reset_mid();
    test_baud_50m();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // watchdog for any wait that never resolves
  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/uart_tx_cfg.md
Name: uart_tx_cfg

Overview:
Parametrised UART transmitter, the successor of the fixed 8N1 transmitter.
- Configurable data width, parity mode and stop-bit count.
- Internal transmit FIFO so producers (sensor formatters, debug printers) can queue bytes without waiting for each frame to finish.
- Sits between the application logic and the board TX pin. Single clock domain.

Parameters:
CLK_FRE, 50, system clock frequency in MHz
UART_RATE, 115200, baud rate in bit/s
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 16, TX FIFO entries, power of two, minimum 2

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
send_en  in  1  write strobe, one entry per asserted cycle
send_data  in  DATA_BITS  data word sampled when send_en && send_ready
send_ready  out  1  FIFO not full
send_drop  out  1  one-cycle pulse: send_en seen while FIFO full, word discarded
fifo_level  out  $clog2(FIFO_DEPTH+1)  entries currently queued
send_busy  out  1  FSM not IDLE or FIFO not empty
tx_pin  out  1  serial output, idle high

Behaviour:
- Interface (already decided): one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values:
  - tx_pin = 1, send_ready = 1, send_drop = 0, fifo_level = 0, send_busy = 0.
  - FSM = IDLE, FIFO pointers = 0, baud counter = 0.
- Reset mid-frame: the frame is aborted and tx_pin = 1 from the next edge. FIFO contents are discarded.
- Bit timing: RATE_CNT = CLK_FRE*1_000_000/UART_RATE - 1, using integer division. Every bit (start, data, parity, stop) lasts exactly RATE_CNT+1 clocks. The baud counter clears at each bit boundary.
- Frame order:
  - Start bit (0).
  - DATA_BITS data bits, LSB first.
  - Parity bit if PARITY != 0: even = XOR of data bits, odd = its inverse.
  - STOP_BITS stop bits (1).
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START when the FIFO is not empty. The head word is popped into the shift register in that same cycle.
  - START -> DATA after 1 bit time.
  - DATA -> PARITY, or STOP if PARITY = 0, after DATA_BITS bit times. A bit index counter 0..DATA_BITS-1 tracks position.
  - PARITY -> STOP after 1 bit time.
  - STOP -> after STOP_BITS bit times:
    - If the FIFO is not empty: pop, go directly to START. No idle gap between back-to-back frames.
    - Otherwise go to IDLE.
- tx_pin is registered and is driven by state: START 0, DATA shift-register bit, PARITY computed bit, STOP/IDLE 1.
- Latency: send_en at edge N with the FIFO empty and the FSM IDLE:
  - Word is in the FIFO after N.
  - Pop occurs at N+1.
  - tx_pin falls at N+2.
- FIFO:
  - Write on send_en && send_ready.
  - Full at FIFO_DEPTH entries.
  - When full, send_en is not written and send_drop pulses the next cycle.
  - A pop in the same cycle does not free space for that cycle's write.
  - Simultaneous push and pop when not full: level unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - fifo_level and send_ready update one cycle after the push/pop.
- Parity is computed from the shift-register copy latched at pop. It is unaffected by later FIFO writes.
- send_busy falls in the cycle after the last stop bit completes with the FIFO empty.

Test Plan:
1. CLK_FRE=1, UART_RATE=250000 (4 clk/bit), 8N1, send 0xA5 -> tx_pin falls 2 clocks after send_en. Line sequence 0,1,0,1,0,0,1,0,1,1, each exactly 4 clocks. send_busy drops after 40 clocks of frame.
2. Same clock, PARITY=2 then PARITY=1, send 0xA5 -> parity bit 0 (even), then 1 (odd). Frame is 11 bit times.
3. DATA_BITS=7, PARITY=2, STOP_BITS=2, send 0x55 -> 0,1,0,1,0,1,0,1,0,1,1, i.e. 7 data bits, parity 0, two stop bits, 44 clocks total.
4. FIFO_DEPTH=4:
   - Issue 6 send_en on consecutive cycles with 0x01..0x06 while idle. The first word is popped at the cycle after its write.
   - Required: 0x06 dropped with send_drop pulsed once, send_ready low while level = 4.
   - Frames 0x01..0x05 are back-to-back with no idle clock between stop and next start.
5. Reset asserted in the middle of data bit 3 of a 0x00 frame with 2 words queued -> tx_pin = 1 the next clock, fifo_level = 0, send_busy = 0. A new send_en after reset produces a clean frame.
6. CLK_FRE=50, UART_RATE=115200, 8N1, 0xFF -> each bit measures 434 clocks. Total frame is 4340 clocks.
